// File: rtl/spike_channel_scheduler_pkg.sv
// Shared types, default constants and threshold arithmetic for the spike
// channel scheduler.
package spike_pkg;

  localparam int unsigned K           = 14;
  localparam int unsigned SCALE_NUM   = 45;
  localparam int unsigned SCALE_SHIFT = 3;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned ACC_W       = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  // Payload held by the one-entry event buffer
  typedef struct packed {
    sample_t data;
    sample_t thr;
  } ev_payload_t;

  // Negative detection threshold from an integrator value; the magnitude
  // saturates to 16 bits so the threshold can never wrap positive.
  function automatic sample_t thr_from_acc(acc_t acc, int unsigned k,
                                           int unsigned scale_num,
                                           int unsigned scale_shift);
    logic signed [63:0] lvl;
    logic signed [63:0] num;
    logic signed [63:0] mag;
    lvl = 64'(acc >>> k);
    num = 64'(scale_num);
    mag = (lvl * num) >>> scale_shift;
    if (mag > 64'sd32767) begin
      return 16'sh8000;
    end else if (mag < -64'sd32767) begin
      return 16'sh7fff;
    end
    return sample_t'(-mag);
  endfunction

  // Magnitude of a sample, with the most negative code folded to full scale
  function automatic logic [SAMPLE_W-1:0] abs16(sample_t x);
    if (x == 16'sh8000) begin
      return 16'h7fff;
    end
    return x[SAMPLE_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/spike_channel_scheduler_if.sv
// Sample-in and event-out handshake bundle of the spike channel scheduler.
//   in_valid/in_ready/in_ch/in_data : sample stream into the detector
//   ev_valid/ev_ready/ev_ch/ev_data/ev_thr : spike event stream out
interface spike_channel_scheduler_if #(
  parameter int unsigned CW = 3
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [CW-1:0]        in_ch;
  spike_pkg::sample_t   in_data;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [CW-1:0]        ev_ch;
  spike_pkg::sample_t   ev_data;
  spike_pkg::sample_t   ev_thr;

  modport master (
    output in_valid, in_ch, in_data, ev_ready,
    input  in_ready, ev_valid, ev_ch, ev_data, ev_thr
  );

  modport slave (
    input  in_valid, in_ch, in_data, ev_ready,
    output in_ready, ev_valid, ev_ch, ev_data, ev_thr
  );

endinterface

// File: rtl/spike_channel_scheduler_bank.sv
// Per-channel register bank holding {acc, wcnt, refr}.
//   rd_ch  -> rd_acc_c/rd_wcnt_c/rd_refr_c : sample-path read port
//   wr_*                                   : single write port
//   thr_ch -> thr_acc_c                    : threshold readout port
module channel_state_bank
  import spike_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CW     = 3,
  parameter int unsigned WCW    = 15,
  parameter int unsigned RCW    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CW-1:0]  rd_ch,
  output acc_t           rd_acc_c,
  output logic [WCW-1:0] rd_wcnt_c,
  output logic [RCW-1:0] rd_refr_c,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  acc_t           wr_acc,
  input  logic [WCW-1:0] wr_wcnt,
  input  logic [RCW-1:0] wr_refr,
  input  logic [CW-1:0]  thr_ch,
  output acc_t           thr_acc_c
);

  acc_t           acc_q  [NUM_CH];
  logic [WCW-1:0] wcnt_q [NUM_CH];
  logic [RCW-1:0] refr_q [NUM_CH];

  // State storage; disabled or stalled channels simply are not written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]  <= '0;
        wcnt_q[i] <= '0;
        refr_q[i] <= '0;
      end
    end else if (wr_en) begin
      acc_q[wr_ch]  <= wr_acc;
      wcnt_q[wr_ch] <= wr_wcnt;
      refr_q[wr_ch] <= wr_refr;
    end
  end

  assign rd_acc_c  = acc_q[rd_ch];
  assign rd_wcnt_c = wcnt_q[rd_ch];
  assign rd_refr_c = refr_q[rd_ch];
  assign thr_acc_c = acc_q[thr_ch];

endmodule

// File: rtl/spike_channel_scheduler.sv
// Time-multiplexed leaky-integrator spike detector shared by NUM_CH channels.
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : sample input stream and spike event output stream
//   ch_en        : per-channel enable; disabled samples are consumed unchanged
//   thr_rd_ch    : threshold readout select
//   thr_rd_data  : registered threshold of thr_rd_ch
module spike_channel_scheduler #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned K           = spike_pkg::K,
  parameter int unsigned SCALE_NUM   = spike_pkg::SCALE_NUM,
  parameter int unsigned SCALE_SHIFT = spike_pkg::SCALE_SHIFT,
  parameter int unsigned WARMUP      = 16384,
  parameter int unsigned REFRACTORY  = 30,
  localparam int unsigned CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spike_channel_scheduler_if.slave  bus,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [CW-1:0]             thr_rd_ch,
  output spike_pkg::sample_t        thr_rd_data
);

  import spike_pkg::*;

  localparam int unsigned WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned RCW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  acc_t                rd_acc_c;
  acc_t                thr_acc_c;
  acc_t                new_acc_c;
  logic [WCW-1:0]      rd_wcnt_c;
  logic [WCW-1:0]      new_wcnt_c;
  logic [RCW-1:0]      rd_refr_c;
  logic [RCW-1:0]      new_refr_c;
  logic [SAMPLE_W-1:0] abs_c;
  sample_t             thr_c;
  logic                accept_c;
  logic                wr_en_c;
  logic                spike_c;

  logic                ev_valid_q;
  logic [CW-1:0]       ev_ch_q;
  ev_payload_t         ev_q;

  // A pending event that is not being taken stalls the whole datapath
  assign bus.in_ready = !ev_valid_q || bus.ev_ready;
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign wr_en_c      = accept_c && ch_en[bus.in_ch];

  // Integrator, warm-up and refractory update from pre-update channel state
  always_comb begin
    abs_c      = abs16(bus.in_data);
    thr_c      = thr_from_acc(rd_acc_c, K, SCALE_NUM, SCALE_SHIFT);
    new_acc_c  = rd_acc_c - (rd_acc_c >>> K) + acc_t'(abs_c);
    new_wcnt_c = (rd_wcnt_c == WCW'(WARMUP)) ? rd_wcnt_c : rd_wcnt_c + WCW'(1);
    spike_c    = wr_en_c && (rd_wcnt_c == WCW'(WARMUP)) && (rd_refr_c == '0) &&
                 (bus.in_data < thr_c);
    new_refr_c = rd_refr_c;
    if (spike_c) begin
      new_refr_c = RCW'(REFRACTORY);
    end else if (rd_refr_c != '0) begin
      new_refr_c = rd_refr_c - RCW'(1);
    end
  end

  channel_state_bank #(
    .NUM_CH (NUM_CH),
    .CW     (CW),
    .WCW    (WCW),
    .RCW    (RCW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_ch     (bus.in_ch),
    .rd_acc_c  (rd_acc_c),
    .rd_wcnt_c (rd_wcnt_c),
    .rd_refr_c (rd_refr_c),
    .wr_en     (wr_en_c),
    .wr_ch     (bus.in_ch),
    .wr_acc    (new_acc_c),
    .wr_wcnt   (new_wcnt_c),
    .wr_refr   (new_refr_c),
    .thr_ch    (thr_rd_ch),
    .thr_acc_c (thr_acc_c)
  );

  // One-entry event buffer; a new spike overrides a same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid_q  <= 1'b0;
      ev_ch_q     <= '0;
      ev_q        <= '0;
      thr_rd_data <= '0;
    end else begin
      if (spike_c) begin
        ev_valid_q <= 1'b1;
        ev_ch_q    <= bus.in_ch;
        ev_q.data  <= bus.in_data;
        ev_q.thr   <= thr_c;
      end else if (bus.ev_ready) begin
        ev_valid_q <= 1'b0;
      end
      thr_rd_data <= thr_from_acc(thr_acc_c, K, SCALE_NUM, SCALE_SHIFT);
    end
  end

  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_ch    = ev_ch_q;
  assign bus.ev_data  = ev_q.data;
  assign bus.ev_thr   = ev_q.thr;

endmodule

// File: tb/tb_spike_channel_scheduler.sv
module tb_spike_channel_scheduler;

  localparam int NCH    = 8;
  localparam int WARMUP = 4;
  localparam int REFR   = 3;

  typedef struct {
    int ch;
    int data;
    int thr;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  ch_en;
  logic [2:0]      thr_rd_ch;
  logic signed [15:0] thr_rd_data;

  spike_channel_scheduler_if #(.CW(3)) bus ();

  spike_channel_scheduler #(
    .NUM_CH     (NCH),
    .WARMUP     (WARMUP),
    .REFRACTORY (REFR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ch_en       (ch_en),
    .thr_rd_ch   (thr_rd_ch),
    .thr_rd_data (thr_rd_data)
  );

  int     checks   = 0;
  int     failures = 0;
  int     ev_seen  = 0;
  exp_t   exp_q[$];
  longint m_acc [NCH];
  int     m_wcnt[NCH];
  int     m_refr[NCH];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: threshold from an integrator value (K=14, 45/8 scale)
  function automatic int m_thr(input longint a);
    longint lvl;
    longint m;
    lvl = a >>> 14;
    m   = (lvl * 45) >>> 3;
    if (m > 32767) return -32768;
    if (m < -32767) return 32767;
    return int'(-m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i]  = 0;
      m_wcnt[i] = 0;
      m_refr[i] = 0;
    end
  endtask

  task automatic model_accept(input int ch, input int data);
    int   ab;
    int   thr;
    bit   sp;
    exp_t e;
    if (!ch_en[ch]) return;
    ab  = (data == -32768) ? 32767 : ((data < 0) ? -data : data);
    thr = m_thr(m_acc[ch]);
    sp  = (m_wcnt[ch] == WARMUP) && (m_refr[ch] == 0) && (data < thr);
    m_acc[ch] = longint'(int'(m_acc[ch] - (m_acc[ch] >>> 14) + ab));
    if (m_wcnt[ch] < WARMUP) m_wcnt[ch]++;
    if (sp) begin
      m_refr[ch] = REFR;
      e.ch = ch; e.data = data; e.thr = thr;
      exp_q.push_back(e);
    end else if (m_refr[ch] > 0) begin
      m_refr[ch]--;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int ch, input int data, input int max_wait);
    int waited;
    bit done;
    waited = 0;
    done   = 0;
    bus.in_valid = 1'b1;
    bus.in_ch    = 3'(ch);
    bus.in_data  = 16'(data);
    while (!done) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        model_accept(ch, data);
        done = 1;
      end else begin
        waited++;
        if (waited >= max_wait) begin
          checks++;
          failures++;
          $display("FAIL send_timeout ch=%0d waited=%0d", ch, waited);
          done = 1;
        end
        @(posedge clk);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every handshaken event against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.ev_valid && bus.ev_ready) begin
        ev_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event ch=%0d data=%0d thr=%0d", bus.ev_ch, bus.ev_data, bus.ev_thr);
        end else begin
          e = exp_q.pop_front();
          chk("ev_ch", int'(bus.ev_ch), e.ch);
          chk("ev_data", int'(bus.ev_data), e.data);
          chk("ev_thr", int'(bus.ev_thr), e.thr);
        end
      end
    end
  end

  initial begin
    int base;
    int pos_seen;
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.in_data  = '0;
    bus.ev_ready = 1'b1;
    ch_en        = '1;
    thr_rd_ch    = '0;
    rst_n        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_ev_valid", int'(bus.ev_valid), 0);
    chk("rst_thr_rd", int'(thr_rd_data), 0);
    @(negedge clk);

    // Most negative sample folds to 32767; thr(32767) = -(1*45>>3) = -5
    send(0, -32768, 5);
    @(negedge clk);
    #1;
    chk("abs_fold_thr", int'(thr_rd_data), -5);
    @(negedge clk);

    // Warm-up on ch2: 100 x 1000 gives acc>>>14 = 6, thr = -33
    thr_rd_ch = 3'd2;
    for (int i = 0; i < 100; i++) send(2, 1000, 5);
    #1;
    chk("warm_thr_rd", int'(thr_rd_data), -33);
    send(2, -32000, 5);
    #1;
    chk("warm_ev_valid", int'(bus.ev_valid), 1);
    chk("warm_ev_ch", int'(bus.ev_ch), 2);
    chk("warm_ev_thr", int'(bus.ev_thr), -33);

    // Gate: four cold negative samples on ch3 do not fire, the fifth does
    for (int i = 0; i < 4; i++) send(3, -32000, 5);
    #1;
    chk("gate_no_event", int'(bus.ev_valid), 0);
    send(3, -32000, 5);
    #1;
    chk("gate_ev_valid", int'(bus.ev_valid), 1);
    chk("gate_ev_ch", int'(bus.ev_ch), 3);
    chk("gate_ev_thr", int'(bus.ev_thr), -39);

    // Refractory on ch2: let refr drain, then 4 spikes give 1 event, 5th fires
    for (int i = 0; i < 3; i++) send(2, 1000, 5);
    base = ev_seen;
    for (int i = 0; i < 4; i++) send(2, -32000, 5);
    repeat (2) @(negedge clk);
    #3;
    chk("refr_one_event", ev_seen - base, 1);
    send(2, -32000, 5);
    repeat (2) @(negedge clk);
    #3;
    chk("refr_second_event", ev_seen - base, 2);

    // Backpressure: pending ch3 event stalls input and freezes state
    for (int i = 0; i < 3; i++) send(2, 1000, 5);
    for (int i = 0; i < 3; i++) send(3, 1000, 5);
    thr_rd_ch = 3'd2;
    @(negedge clk);
    bus.ev_ready = 1'b0;
    send(3, -32000, 5);
    bus.in_valid = 1'b1;
    bus.in_ch    = 3'd2;
    bus.in_data  = -16'sd32000;
    repeat (10) begin
      #1;
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_ev_valid", int'(bus.ev_valid), 1);
      chk("bp_ev_ch", int'(bus.ev_ch), 3);
      chk("bp_thr_hold", int'(thr_rd_data), m_thr(m_acc[2]));
      @(negedge clk);
    end
    bus.ev_ready = 1'b1;
    send(2, -32000, 5);
    #1;
    chk("bp_release_valid", int'(bus.ev_valid), 1);
    chk("bp_release_ch", int'(bus.ev_ch), 2);
    @(negedge clk);

    // Round-robin with ch5 disabled
    ch_en = 8'hDF;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < NCH; c++) send(c, 2000 + c * 3000, 5);
    ch_en = '1;
    for (int c = 0; c < NCH; c++) begin
      thr_rd_ch = 3'(c);
      @(negedge clk);
      #1;
      chk("rr_thr", int'(thr_rd_data), m_thr(m_acc[c]));
      if (c == 5) chk("rr_ch5_untouched", int'(thr_rd_data), 0);
      @(negedge clk);
    end

    // Saturation: long full-scale stream on ch6
    thr_rd_ch = 3'd6;
    pos_seen  = 0;
    @(negedge clk);
    for (int i = 0; i < 4000; i++) begin
      send(6, 32767, 5);
      if (thr_rd_data > 0) pos_seen++;
    end
    @(negedge clk);
    #1;
    chk("sat_thr", int'(thr_rd_data), -32768);
    chk("sat_model", int'(thr_rd_data), m_thr(m_acc[6]));
    chk("sat_never_pos", pos_seen, 0);
    @(negedge clk);
    send(6, -32768, 5);
    repeat (2) @(negedge clk);

    // Reset mid-operation drops the pending event and all state
    bus.ev_ready = 1'b0;
    send(1, -32000, 5);
    #1;
    chk("pre_rst_pending", int'(bus.ev_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ev_valid", int'(bus.ev_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_thr_rd", int'(thr_rd_data), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.ev_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_thr6", int'(thr_rd_data), 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
